// File: rtl/fft64_stage_ctrl.sv
// Column sequencer for the two-stage radix-8 64-point FFT: admits eight columns per frame
// and tags them through stage 1, the intermediate bank and stage 2. Option: FFT64_STAGE_CTRL_OVERLAP_EN.
module fft64_stage_ctrl #(
    parameter int STAGE1_LAT = 2,
    parameter int STAGE2_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] in_col,
    output logic       inter_en,
    output logic [2:0] tw_col,
    output logic       out_valid,
    output logic [2:0] out_col,
    output logic       done,
    output logic       busy,
    output logic [7:0] frame_cnt,
    output logic [1:0] state_dbg
);
    // Handshake: a column transfers on a cycle where in_valid && in_ready are both high;
    // in_valid may drop at any time and the downstream pipeline never stalls.
    localparam int DEPTH = STAGE1_LAT + 1 + STAGE2_LAT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       col_cnt;
    logic             cur_tag;
    logic [DEPTH-1:0] pipe_vld;
    logic [DEPTH-1:0] pipe_tag;
    logic [2:0]       pipe_col [DEPTH];
    logic             accept;
    logic             last_done;

    assign in_ready  = (state == LOAD);
    assign accept    = in_valid && in_ready;
    assign in_col    = col_cnt;
    assign inter_en  = pipe_vld[STAGE1_LAT-1];
    assign tw_col    = pipe_col[STAGE1_LAT-1];
    assign out_valid = pipe_vld[DEPTH-1];
    assign out_col   = pipe_col[DEPTH-1];
    assign done      = out_valid && (out_col == 3'd7);
    // The tag flips per frame, so only the newest frame's final column ends DRAIN.
    assign last_done = done && (pipe_tag[DEPTH-1] == cur_tag);
    assign busy      = (state != IDLE) || (|pipe_vld);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            pipe_tag <= '0;
            for (int i = 0; i < DEPTH; i++) pipe_col[i] <= 3'd0;
        end else begin
            pipe_vld    <= {pipe_vld[DEPTH-2:0], accept};
            pipe_tag    <= {pipe_tag[DEPTH-2:0], cur_tag};
            pipe_col[0] <= col_cnt;
            for (int i = 1; i < DEPTH; i++) pipe_col[i] <= pipe_col[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            col_cnt   <= 3'd0;
            cur_tag   <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            if (done) frame_cnt <= frame_cnt + 8'd1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        col_cnt <= 3'd0;
                        cur_tag <= ~cur_tag;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        col_cnt <= col_cnt + 3'd1;
                        if (col_cnt == 3'd7) state <= DRAIN;
                    end
                end
                DRAIN: begin
`ifdef FFT64_STAGE_CTRL_OVERLAP_EN
                    if (start) begin
                        state   <= LOAD;
                        col_cnt <= 3'd0;
                        cur_tag <= ~cur_tag;
                    end else if (last_done) begin
                        state <= IDLE;
                    end
`else
                    if (last_done) state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft64_stage_ctrl.sv
// Randomized scoreboard bench for fft64_stage_ctrl, plus a directed latency check of a
// STAGE1_LAT=1 / STAGE2_LAT=4 instance.
module tb_fft64_stage_ctrl;
  localparam int S1  = 2;
  localparam int S2  = 2;
  localparam int LAT = S1 + 1 + S2;
  localparam int W   = 19;
`ifdef FFT64_STAGE_CTRL_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready, inter_en, out_valid, done, busy;
  logic [2:0] in_col, tw_col, out_col;
  logic [7:0] frame_cnt;
  logic [1:0] state_dbg;

  logic rst_b = 1'b1;
  logic start_b = 1'b0;
  logic in_valid_b = 1'b0;
  logic in_ready_b, inter_en_b, out_valid_b, done_b, busy_b;
  logic [2:0] in_col_b, tw_col_b, out_col_b;
  logic [7:0] frame_cnt_b;
  logic [1:0] state_dbg_b;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  // ---------------- clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  fft64_stage_ctrl #(.STAGE1_LAT(S1), .STAGE2_LAT(S2)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_col(in_col), .inter_en(inter_en), .tw_col(tw_col),
    .out_valid(out_valid), .out_col(out_col), .done(done), .busy(busy),
    .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );

  fft64_stage_ctrl #(.STAGE1_LAT(1), .STAGE2_LAT(4)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .in_col(in_col_b), .inter_en(inter_en_b), .tw_col(tw_col_b),
    .out_valid(out_valid_b), .out_col(out_col_b), .done(done_b), .busy(busy_b),
    .frame_cnt(frame_cnt_b), .state_dbg(state_dbg_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (frame-level: mode, column count, drain end cycle)
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DRAIN = 2;
  logic [W-1:0] tw_q[$];
  logic [W-1:0] exp_q[$];
  int m_state = M_IDLE;
  int m_col = 0;
  int m_end = 0;
  int m_frames = 0;
  int last_acc = -1000;
  bit rst_pend = 1'b0;
  bit chk_en = 1'b0;
  bit post_rst = 1'b0;
  bit e_ready, e_busy, e_idle;
  logic [2:0] e_col;

  task automatic drive(input logic s, input logic v, input logic r);
    bit acc;
    @(posedge clk);
    #1;
    if (rst_pend) begin
      tw_q.delete();
      exp_q.delete();
      m_state = M_IDLE;
      m_col = 0;
      m_frames = 0;
      last_acc = -1000;
      rst_pend = 1'b0;
      post_rst = 1'b1;
      chk_en = 1'b1;
    end else begin
      post_rst = 1'b0;
    end
    start = s;
    in_valid = v;
    rst = r;
    e_ready = (m_state == M_LOAD);
    e_col = 3'(m_col);
    e_idle = (m_state == M_IDLE);
    e_busy = (m_state != M_IDLE) || (cyc <= last_acc + LAT);
    acc = v && e_ready;
    if (acc) begin
      tw_q.push_back({16'(cyc + S1), 3'(m_col)});
      exp_q.push_back({16'(cyc + LAT), 3'(m_col)});
      last_acc = cyc;
    end
    case (m_state)
      M_IDLE: if (s) begin m_state = M_LOAD; m_col = 0; end
      M_LOAD: if (acc) begin
        if (m_col == 7) begin m_state = M_DRAIN; m_end = cyc + LAT; end
        m_col = (m_col + 1) % 8;
      end
      default: begin
        if (OVL && s) begin m_state = M_LOAD; m_col = 0; end
        else if (cyc == m_end) m_state = M_IDLE;
      end
    endcase
    if (r) rst_pend = 1'b1;
  endtask

  // ---------------- scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("in_col", 32'(in_col), 32'(e_col));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("state_idle", 32'(state_dbg == 2'd0), 32'(e_idle));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_frames % 256));
      if (tw_q.size() > 0 && tw_q[0][W-1:3] == 16'(cyc)) begin
        e = tw_q.pop_front();
        chk("inter_en", 32'(inter_en), 32'd1);
        chk("tw_col", 32'(tw_col), 32'(e[2:0]));
      end else begin
        chk("inter_en_idle", 32'(inter_en), 32'd0);
      end
      if (exp_q.size() > 0 && exp_q[0][W-1:3] == 16'(cyc)) begin
        e = exp_q.pop_front();
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_col", 32'(out_col), 32'(e[2:0]));
        chk("done", 32'(done), 32'(e[2:0] == 3'd7));
        if (e[2:0] == 3'd7) m_frames++;
      end else begin
        chk("out_valid_idle", 32'(out_valid), 32'd0);
        chk("done_idle", 32'(done), 32'd0);
      end
      if (post_rst) begin
        chk("rst_tw_col", 32'(tw_col), 32'd0);
        chk("rst_out_col", 32'(out_col), 32'd0);
      end
    end
  end

  // ---------------- directed check of the STAGE1_LAT=1 / STAGE2_LAT=4 instance
  task automatic test_b();
    int t0;
    int fi = -1;
    int fo = -1;
    int fd = -1;
    int ndone = 0;
    logic [2:0] ftw = 3'd7;
    logic [2:0] foc = 3'd7;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    start_b = 1'b1;
    t0 = cyc;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      start_b = 1'b0;
      in_valid_b = (i <= 8);
      @(negedge clk);
      if (inter_en_b && fi < 0) begin fi = cyc; ftw = tw_col_b; end
      if (out_valid_b && fo < 0) begin fo = cyc; foc = out_col_b; end
      if (done_b) begin fd = cyc; ndone++; end
    end
    chk("b_inter_en_cycle", 32'(fi - t0), 32'd2);
    chk("b_tw_col0", 32'(ftw), 32'd0);
    chk("b_out_valid_cycle", 32'(fo - t0), 32'd7);
    chk("b_out_col0", 32'(foc), 32'd0);
    chk("b_done_cycle", 32'(fd - t0), 32'd14);
    chk("b_done_count", 32'(ndone), 32'd1);
    chk("b_frame_cnt", 32'(frame_cnt_b), 32'd1);
    chk("b_busy_end", 32'(busy_b), 32'd0);
  endtask

  // ---------------- stimulus
  initial begin
    repeat (3) drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    // back-to-back frame
    drive(1'b1, 1'b0, 1'b0);
    repeat (8) drive(1'b0, 1'b1, 1'b0);
    repeat (8) drive(1'b0, 1'b0, 1'b0);

    // in_valid on alternate cycles
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) drive(1'b0, logic'(i % 2), 1'b0);
    repeat (8) drive(1'b0, 1'b0, 1'b0);

    // second start while draining (honoured only with overlap)
    drive(1'b1, 1'b0, 1'b0);
    repeat (8) drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    repeat (12) drive(1'b0, 1'b1, 1'b0);
    repeat (10) drive(1'b0, 1'b0, 1'b0);

    // reset mid-load
    drive(1'b1, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    repeat (10) drive(1'b0, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 249) == 0));
    end
    drive(1'b0, 1'b0, 1'b0);
    repeat (20) drive(1'b0, 1'b0, 1'b0);
    chk("tw_q_empty", 32'(tw_q.size()), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk_en = 1'b0;

    test_b();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft64_stage_ctrl.md
# fft64_stage_ctrl

Sequencing controller for the two-stage radix-8 64-point FFT datapath. It accepts one frame as eight 8-sample columns through a valid/ready handshake and tracks each column through stage-1 butterflies, the 8×32-bit intermediate register bank, and stage-2 butterflies. It drives the per-column index, the intermediate-bank load enable, the twiddle column select and the output-valid/done strobes. It holds no sample data; it only schedules the datapath around it.

## Interface
- STAGE1_LAT, default 2: stage-1 butterfly latency in cycles, legal range 1..8.
- STAGE2_LAT, default 2: stage-2 butterfly latency in cycles, legal range 1..8.
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  frame start request.
- in_valid  in  1  upstream presents one column.
- in_ready  out  1  controller accepts a column this cycle.
- in_col  out  3  index of the column being accepted (0..7).
- inter_en  out  1  load enable for the intermediate register bank.
- tw_col  out  3  twiddle column select, aligned with inter_en.
- out_valid  out  1  stage-2 output column valid.
- out_col  out  3  index of the output column.
- done  out  1  one-cycle pulse: last column of a frame is leaving.
- busy  out  1  frame loading or columns in flight.
- frame_cnt  out  8  completed-frame counter.

## Operation
- FSM states:
  - IDLE: wait for a frame start.
  - LOAD: accept columns 0..7.
  - DRAIN: wait for in-flight columns to finish.
- Transitions:
  - IDLE -> LOAD on start.
  - LOAD -> DRAIN on the cycle column 7 is accepted.
  - DRAIN -> IDLE on the cycle done pulses.
- A column is accepted when in_valid && in_ready.
- in_ready = (state==LOAD). in_col = column counter, which resets to 0 on entry to LOAD and increments on each accept.
- in_valid gaps are allowed. The tracking pipeline shifts every cycle, so gaps propagate as bubbles; there is no backpressure downstream.
- Tracking pipeline: shift register of {valid, col[2:0]}, depth STAGE1_LAT+1+STAGE2_LAT.
- inter_en/tw_col are tapped at depth STAGE1_LAT. out_valid/out_col are tapped at the final stage.
- done = out_valid && out_col==7. It is derived from the pipeline, not from the FSM state.
- frame_cnt increments on done and wraps 255 -> 0.
- busy = (state!=IDLE) || any pipeline valid bit set.
- start is ignored in LOAD. In DRAIN it is ignored unless the overlap feature is enabled (see Configuration).
- Reset values, all outputs: in_ready=0, in_col=0, inter_en=0, tw_col=0, out_valid=0, out_col=0, done=0, busy=0, frame_cnt=0. The FSM resets to IDLE and all pipeline valid bits clear.
- Reset asserted mid-frame discards every in-flight column. No done pulse is produced for the aborted frame.

## Timing
- start at cycle t in IDLE -> in_ready=1 from t+1.
- Column c accepted at cycle a:
  - inter_en=1 with tw_col=c at a+STAGE1_LAT.
  - out_valid=1 with out_col=c at a+STAGE1_LAT+1+STAGE2_LAT.
  - Default latency is 5 cycles.
- Back-to-back accepts: minimum frame is 8 load cycles. With defaults and in_valid held high from t+1, done pulses at t+13 and busy falls at t+14.
- The FSM returns to IDLE the cycle after done. start in that same cycle (IDLE) is honoured on the next edge.
- start and done in the same cycle in DRAIN: the done pulse still fires. The state then goes to IDLE (overlap disabled) or LOAD (overlap enabled).

## Configuration
- FFT64_STAGE_CTRL_OVERLAP_EN defined:
  - start in DRAIN moves the FSM to LOAD next cycle with the column counter cleared.
  - A new frame loads while the previous one drains. done and frame_cnt still track each frame via the pipeline tag.
  - After the new frame's column 7 is accepted, the FSM enters DRAIN. It leaves DRAIN only on the done of the latest frame; an earlier frame's done pulse does not cause the transition.
- Undefined: start is honoured only in IDLE, so frames are strictly serialized.

## Test plan
- Reset, then start at cycle 0 with in_valid held 1 (defaults):
  - in_col 0..7 accepted at cycles 1..8.
  - inter_en at 3..10 with tw_col 0..7.
  - out_valid at 6..13.
  - done at 13, frame_cnt=1, busy=0 at 14.
- in_valid low on alternate cycles: accepts at 1,3,...,15; out_valid at 6,8,...,20; done at 20.
- rst pulsed at cycle 5 mid-load: all outputs read zero next cycle, no done pulse, frame_cnt=0, FSM in IDLE.
- Overlap enabled, second start at cycle 9 (DRAIN):
  - in_ready=1 at 10.
  - First done at 13, second done at 22 (in_valid held 1).
  - frame_cnt=2.
- Overlap disabled, same start at cycle 9: ignored, in_ready stays 0, only one done (cycle 13).
- STAGE1_LAT=1, STAGE2_LAT=4, column 0 accepted at cycle 1: inter_en at 2, out_valid at 7.
